// File: rtl/rr_arbiter_4_seg.sv
// Four-way round-robin arbiter with a per-owner quantum limit.
// Shows the granted index on an active-low 7-segment digit, or a dash when idle.
module rr_arbiter_4_seg #(
  parameter int QUANTUM = 8,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic [6:0] seg
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CW-1:0] QMAX = CW'(QUANTUM);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        r_state, w_stateNext;
  logic [1:0]    r_ptr, w_ptrNext;
  logic [CW-1:0] r_cnt, w_cntNext;
  logic [3:0]    r_gnt, w_gntNext;
  logic [1:0]    r_idx, w_idxNext;
  logic [3:0]    w_others;
  logic [1:0]    w_afterOwner;

  // First set bit of m, scanning upward from start and wrapping modulo 4.
  function automatic logic [1:0] pickNext(input logic [3:0] m, input logic [1:0] start);
    logic [1:0] sel;
    logic [1:0] cand;
    sel = start;
    for (int i = 3; i >= 0; i--) begin
      cand = start + 2'(i);
      if (m[cand]) sel = cand;
    end
    return sel;
  endfunction

  assign w_others     = req & ~r_gnt;
  assign w_afterOwner = r_idx + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
      r_gnt   <= 4'b0000;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_stateNext;
      r_ptr   <= w_ptrNext;
      r_cnt   <= w_cntNext;
      r_gnt   <= w_gntNext;
      r_idx   <= w_idxNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_ptrNext   = r_ptr;
    w_cntNext   = r_cnt;
    w_gntNext   = r_gnt;
    w_idxNext   = r_idx;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_idxNext   = pickNext(req, r_ptr);
          w_gntNext   = 4'b0001 << w_idxNext;
          w_cntNext   = ONE;
          w_stateNext = BUSY;
        end
      end
      BUSY: begin
        if (!req[r_idx]) begin
          // Release: the pointer moves past the owner before the re-search.
          w_ptrNext = w_afterOwner;
          if (|req) begin
            w_idxNext = pickNext(req, w_afterOwner);
            w_gntNext = 4'b0001 << w_idxNext;
            w_cntNext = ONE;
          end else begin
            w_gntNext   = 4'b0000;
            w_cntNext   = '0;
            w_stateNext = IDLE;
          end
        end else if (r_cnt == QMAX) begin
          w_cntNext = ONE;
          if (|w_others) begin
            w_ptrNext = w_afterOwner;
            w_idxNext = pickNext(w_others, w_afterOwner);
            w_gntNext = 4'b0001 << w_idxNext;
          end
        end else if (r_cnt < QMAX) begin
          w_cntNext = r_cnt + ONE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = |r_gnt;

  always_comb begin
    seg = 7'b0111111;
    if (gnt_valid) begin
      case (r_idx)
        2'd0: seg = 7'b1000000;
        2'd1: seg = 7'b1111001;
        2'd2: seg = 7'b0100100;
        2'd3: seg = 7'b0110000;
        default: seg = 7'b0111111;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4_seg.sv
// Bench for rr_arbiter_4_seg: one instance with QUANTUM=8 and one with QUANTUM=1,
// exercised by directed sequences, a vector table and random traffic against a model.
module tb_rr_arbiter_4_seg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req8 = 4'b0000;
  logic [3:0] req1 = 4'b0000;
  logic [3:0] gnt8, gnt1;
  logic [1:0] idx8, idx1;
  logic       valid8, valid1;
  logic [6:0] seg8, seg1;

  int nCompared = 0;
  int nFailed   = 0;

  always #5 clk = ~clk;

  rr_arbiter_4_seg #(.QUANTUM(8), .CW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8),
    .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(valid8), .seg(seg8)
  );

  rr_arbiter_4_seg #(.QUANTUM(1), .CW(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1),
    .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(valid1), .seg(seg1)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] expGnt;
    logic [1:0] expIdx;
  } vector_t;

  // Reference model state, one slot per instance (0: QUANTUM=8, 1: QUANTUM=1).
  int mOwner[2];
  int mPtr[2];
  int mHeld[2];
  int mLast[2];
  int qOf[2] = '{8, 1};

  function automatic logic [6:0] segOf(input logic valid, input logic [1:0] idx);
    logic [6:0] digits [4];
    digits = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};
    return valid ? digits[idx] : 7'b0111111;
  endfunction

  function automatic int firstFrom(input logic [3:0] m, input int start);
    for (int i = 0; i < 4; i++)
      if (m[(start + i) % 4]) return (start + i) % 4;
    return -1;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mOwner[d] = -1;
      mPtr[d]   = 0;
      mHeld[d]  = 0;
      mLast[d]  = 0;
    end
  endtask

  // Advance the model by one clock edge given the request vector seen at that edge.
  task automatic modelStep(input int d, input logic [3:0] r);
    logic [3:0] others;
    if (mOwner[d] < 0) begin
      if (r != 0) begin
        mOwner[d] = firstFrom(r, mPtr[d]);
        mHeld[d]  = 1;
      end
    end else if (!r[mOwner[d]]) begin
      mPtr[d]   = (mOwner[d] + 1) % 4;
      mOwner[d] = firstFrom(r, mPtr[d]);
      mHeld[d]  = (mOwner[d] < 0) ? 0 : 1;
    end else begin
      others = r & ~(4'b0001 << mOwner[d]);
      if (mHeld[d] == qOf[d]) begin
        if (others != 0) begin
          mPtr[d]   = (mOwner[d] + 1) % 4;
          mOwner[d] = firstFrom(others, mPtr[d]);
        end
        mHeld[d] = 1;
      end else begin
        mHeld[d]++;
      end
    end
    if (mOwner[d] >= 0) mLast[d] = mOwner[d];
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkDut(input string tag, input int d, input logic [3:0] eGnt, input logic [1:0] eIdx);
    logic [3:0] g;
    logic [1:0] x;
    logic       v;
    logic [6:0] s;
    g = (d == 0) ? gnt8 : gnt1;
    x = (d == 0) ? idx8 : idx1;
    v = (d == 0) ? valid8 : valid1;
    s = (d == 0) ? seg8 : seg1;
    checkOutput({tag, " gnt"}, int'(g), int'(eGnt));
    checkOutput({tag, " idx"}, int'(x), int'(eIdx));
    checkOutput({tag, " valid"}, int'(v), int'(eGnt != 0));
    checkOutput({tag, " seg"}, int'(s), int'(segOf(eGnt != 0, eIdx)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r8, input logic [3:0] r1);
    req8 = r8;
    req1 = r1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000);
    tick();
    tick();
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    vector_t vecs [11];
    logic [3:0] r8, r1;
    int owner1;

    vecs[0]  = '{4'b0100, 4'b0100, 2'd2};
    vecs[1]  = '{4'b0100, 4'b0100, 2'd2};
    vecs[2]  = '{4'b0000, 4'b0000, 2'd2};
    vecs[3]  = '{4'b1011, 4'b1000, 2'd3};
    vecs[4]  = '{4'b0011, 4'b0001, 2'd0};
    vecs[5]  = '{4'b1010, 4'b0010, 2'd1};
    vecs[6]  = '{4'b1011, 4'b0010, 2'd1};
    vecs[7]  = '{4'b1001, 4'b1000, 2'd3};
    vecs[8]  = '{4'b0001, 4'b0001, 2'd0};
    vecs[9]  = '{4'b0000, 4'b0000, 2'd0};
    vecs[10] = '{4'b0101, 4'b0100, 2'd2};

    // Reset held with requests pending, then fairness / QUANTUM=1 alternation.
    rst_n = 1'b0;
    applyStimulus(4'b1111, 4'b1010);
    tick();
    tick();
    checkDut("reset q8", 0, 4'b0000, 2'd0);
    checkDut("reset q1", 1, 4'b0000, 2'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      checkDut("fair q8", 0, 4'b0001 << ((c / 8) % 4), 2'((c / 8) % 4));
      checkDut("alt q1", 1, (c % 2 == 0) ? 4'b0010 : 4'b1000, (c % 2 == 0) ? 2'd1 : 2'd3);
      checkOutput("onehot q1", int'($onehot(gnt1)), 1);
    end

    // Single requester: continuous grant across quantum renewals, then drop.
    doReset();
    applyStimulus(4'b0100, 4'b0000);
    for (int c = 0; c < 20; c++) begin
      tick();
      checkDut("single", 0, 4'b0100, 2'd2);
    end
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkDut("single drop", 0, 4'b0000, 2'd2);

    // Async reset asserted between edges while requester 1 owns the grant.
    doReset();
    applyStimulus(4'b0010, 4'b0000);
    tick();
    checkDut("pre-async", 0, 4'b0010, 2'd1);
    applyStimulus(4'b1111, 4'b0000);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkDut("async rst", 0, 4'b0000, 2'd0);
    rst_n = 1'b1;
    tick();
    checkDut("post-async", 0, 4'b0001, 2'd0);

    // Vector table on the QUANTUM=8 instance.
    doReset();
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].req, 4'b0000);
      tick();
      checkDut($sformatf("vec%0d", i), 0, vecs[i].expGnt, vecs[i].expIdx);
    end

    // Random traffic with sticky requests so quanta actually expire.
    doReset();
    r8 = 4'b0000;
    r1 = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) r8[b] = ~r8[b];
        if ($urandom_range(0, 3) == 0) r1[b] = ~r1[b];
      end
      applyStimulus(r8, r1);
      tick();
      modelStep(0, r8);
      modelStep(1, r1);
      checkDut("rand q8", 0, (mOwner[0] < 0) ? 4'b0000 : 4'(4'b0001 << mOwner[0]), 2'(mLast[0]));
      owner1 = mOwner[1];
      checkDut("rand q1", 1, (owner1 < 0) ? 4'b0000 : 4'(4'b0001 << owner1), 2'(mLast[1]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
